// File: rtl/board_reader_pkg.sv
// Shared constants for the board reader, board writer and update engine:
// board geometry, browse-index width and the stream FSM state encoding.
package board_reader_pkg;

    localparam int ROWS      = 16;
    localparam int COLS      = 16;
    localparam int ROW_IDX_W = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/board_reader_btn_edge.sv
// Rising-edge detector for a synchronous level button. Keeps the last two
// samples of the button and pulses for one cycle on a 0->1 change. The
// history clears to 0 on reset, so a button already held high at reset
// release still produces one pulse.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic [1:0] hist_r;

    // Shift the current button level into the two-sample history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r <= 2'b00;
        end else begin
            hist_r <= {hist_r[0], btn};
        end
    end

    assign pulse = hist_r[0] & ~hist_r[1];

endmodule

// File: rtl/board_reader.sv
// Board reader: keeps a frozen shadow copy of the live board, lets the user
// browse its rows with up/down buttons, and streams all rows to a
// ready/valid sink on request. All outputs are registered.
module board_reader #(
    parameter int ROWS = board_reader_pkg::ROWS,
    parameter int COLS = board_reader_pkg::COLS
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic                                 BtnU,
    input  logic                                 BtnD,
    input  logic                                 snapshot,
    input  logic [ROWS*COLS-1:0]                 board_in,
    input  logic                                 stream_start,
    input  logic                                 stream_ready,
    output logic [COLS-1:0]                      row_leds,
    output logic [board_reader_pkg::ROW_IDX_W-1:0] row_idx,
    output logic [COLS-1:0]                      stream_data,
    output logic                                 stream_valid,
    output logic                                 stream_last,
    output logic                                 busy
);

    import board_reader_pkg::*;

    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);
    localparam logic [ROW_IDX_W-1:0] IDX_ONE  = ROW_IDX_W'(1);
    localparam logic [ROW_IDX_W-1:0] IDX_ZERO = ROW_IDX_W'(0);

    logic                     btn_u_pulse_s;
    logic                     btn_d_pulse_s;
    logic [0:0]               state_r;
    logic [0:0]               state_nx_s;
    logic [ROW_IDX_W-1:0]     ptr_r;
    logic [ROW_IDX_W-1:0]     ptr_nx_s;
    logic [ROW_IDX_W-1:0]     row_idx_r;
    logic [ROW_IDX_W-1:0]     row_idx_nx_s;
    logic [ROWS*COLS-1:0]     shadow_r;
    logic [ROWS*COLS-1:0]     shadow_nx_s;
    logic [COLS-1:0]          row_leds_r;
    logic [COLS-1:0]          stream_data_r;
    logic                     stream_valid_r;
    logic                     stream_last_r;
    logic                     busy_r;

    // Extract one row of a flattened board
    function automatic logic [COLS-1:0] row_sel(input logic [ROWS*COLS-1:0] board,
                                                input logic [ROW_IDX_W-1:0] idx);
        return board[int'(idx)*COLS +: COLS];
    endfunction

    btn_edge u_btn_up (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (BtnU),
        .pulse (btn_u_pulse_s)
    );

    btn_edge u_btn_down (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (BtnD),
        .pulse (btn_d_pulse_s)
    );

    // Stream FSM and shadow capture: the shadow only loads while idle, so
    // requests arriving mid-stream are ignored and the stream stays frozen
    always_comb begin
        state_nx_s  = state_r;
        ptr_nx_s    = ptr_r;
        shadow_nx_s = shadow_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && (snapshot || stream_start)) begin
                    shadow_nx_s = board_in;
                end else begin
                    shadow_nx_s = shadow_r;
                end
                if (enable && stream_start) begin
                    state_nx_s = ST_SEND;
                    ptr_nx_s   = IDX_ZERO;
                end else begin
                    state_nx_s = ST_IDLE;
                    ptr_nx_s   = ptr_r;
                end
            end
            ST_SEND: begin
                if (stream_valid_r && stream_ready) begin
                    if (ptr_r == LAST_ROW) begin
                        state_nx_s = ST_IDLE;
                        ptr_nx_s   = IDX_ZERO;
                    end else begin
                        state_nx_s = ST_SEND;
                        ptr_nx_s   = ptr_r + IDX_ONE;
                    end
                end else begin
                    state_nx_s = ST_SEND;
                    ptr_nx_s   = ptr_r;
                end
            end
            default: begin
                state_nx_s  = ST_IDLE;
                ptr_nx_s    = IDX_ZERO;
                shadow_nx_s = shadow_r;
            end
        endcase
    end

    // Browse index: one step per button edge, saturating, opposing edges cancel
    always_comb begin
        row_idx_nx_s = row_idx_r;
        if (enable && btn_u_pulse_s && !btn_d_pulse_s && (row_idx_r != IDX_ZERO)) begin
            row_idx_nx_s = row_idx_r - IDX_ONE;
        end else if (enable && btn_d_pulse_s && !btn_u_pulse_s && (row_idx_r != LAST_ROW)) begin
            row_idx_nx_s = row_idx_r + IDX_ONE;
        end else begin
            row_idx_nx_s = row_idx_r;
        end
    end

    // State registers; stream outputs are built from next-state values so
    // they line up with the FSM in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            ptr_r          <= IDX_ZERO;
            row_idx_r      <= IDX_ZERO;
            shadow_r       <= {(ROWS*COLS){1'b0}};
            row_leds_r     <= {COLS{1'b0}};
            stream_data_r  <= {COLS{1'b0}};
            stream_valid_r <= 1'b0;
            stream_last_r  <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            ptr_r          <= ptr_nx_s;
            row_idx_r      <= row_idx_nx_s;
            shadow_r       <= shadow_nx_s;
            row_leds_r     <= row_sel(shadow_r, row_idx_r);
            stream_data_r  <= (state_nx_s == ST_SEND) ? row_sel(shadow_nx_s, ptr_nx_s) : {COLS{1'b0}};
            stream_valid_r <= (state_nx_s == ST_SEND);
            stream_last_r  <= (state_nx_s == ST_SEND) && (ptr_nx_s == LAST_ROW);
            busy_r         <= (state_nx_s == ST_SEND);
        end
    end

    assign row_leds     = row_leds_r;
    assign row_idx      = row_idx_r;
    assign stream_data  = stream_data_r;
    assign stream_valid = stream_valid_r;
    assign stream_last  = stream_last_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_board_reader.sv
// Directed bench for board_reader: browsing, saturation, snapshot, full-board
// streaming with a scoreboard queue, back-pressure, mid-stream disturbances
// and reset during a stream.
module tb_board_reader;

    localparam int ROWS = 16;
    localparam int COLS = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b0;
    logic                 BtnU = 1'b0;
    logic                 BtnD = 1'b0;
    logic                 snapshot = 1'b0;
    logic                 stream_start = 1'b0;
    logic                 stream_ready = 1'b0;
    logic [ROWS*COLS-1:0] board_in = '0;
    logic [COLS-1:0]      row_leds;
    logic [3:0]           row_idx;
    logic [COLS-1:0]      stream_data;
    logic                 stream_valid;
    logic                 stream_last;
    logic                 busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [COLS-1:0]      exp_q[$];
    logic [ROWS*COLS-1:0] exp_board = '0;
    logic [ROWS*COLS-1:0] b = '0;

    always #5 clk = ~clk;

    board_reader #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .BtnU         (BtnU),
        .BtnD         (BtnD),
        .snapshot     (snapshot),
        .board_in     (board_in),
        .stream_start (stream_start),
        .stream_ready (stream_ready),
        .row_leds     (row_leds),
        .row_idx      (row_idx),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .stream_last  (stream_last),
        .busy         (busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic u, input logic d);
        BtnU = u;
        BtnD = d;
        tick();
        tick();
        BtnU = 1'b0;
        BtnD = 1'b0;
        tick();
    endtask

    // Drive a stream request at the current negedge and queue the rows expected
    task automatic start_stream(input logic [ROWS*COLS-1:0] brd, input logic snap);
        enable       = 1'b1;
        board_in     = brd;
        stream_start = 1'b1;
        snapshot     = snap;
        exp_board    = brd;
        for (int r = 0; r < ROWS; r++) exp_q.push_back(brd[r*COLS +: COLS]);
        tick();
        stream_start = 1'b0;
        snapshot     = 1'b0;
        check("start_busy", busy, 1);
        check("start_valid", stream_valid, 1);
    endtask

    // Consume beats, comparing against the scoreboard and checking stalls
    task automatic run_stream(input bit rnd, input bit perturb, input int stop_after);
        int              beats = 0;
        int              cyc = 0;
        bit              stalled = 1'b0;
        logic [COLS-1:0] held_d = '0;
        logic            held_l = 1'b0;
        logic [COLS-1:0] e;
        while (beats < stop_after && cyc < 600) begin
            if (stalled) begin
                check("stall_data", stream_data, held_d);
                check("stall_last", stream_last, held_l);
            end
            check("valid_in_send", stream_valid, 1);
            stream_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (perturb && beats == 5) begin
                board_in     = ~exp_board;
                snapshot     = 1'b1;
                stream_start = 1'b1;
            end else begin
                snapshot     = 1'b0;
                stream_start = 1'b0;
            end
            enable = !(perturb && beats >= 10);
            if (stream_valid && stream_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $error("FAIL extra_beat: observed=%0h expected=none", stream_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", stream_data, e);
                    check("beat_last", stream_last, (beats == ROWS - 1));
                end
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held_d  = stream_data;
                held_l  = stream_last;
            end
            tick();
            cyc++;
        end
        snapshot     = 1'b0;
        stream_start = 1'b0;
        enable       = 1'b1;
        if (beats < stop_after) begin
            n_chk++;
            n_fail++;
            $error("FAIL stream_timeout: observed=%0d beats expected=%0d", beats, stop_after);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_row_idx", row_idx, 0);
        check("rst_row_leds", row_leds, 0);
        check("rst_valid", stream_valid, 0);
        check("rst_data", stream_data, 0);
        check("rst_last", stream_last, 0);
        check("rst_busy", busy, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();

        // Snapshot then browse to row 3
        board_in = '0;
        board_in[3*COLS +: COLS] = 16'hA5A5;
        snapshot = 1'b1;
        tick();
        snapshot = 1'b0;
        tick();
        tick();
        check("leds_row0", row_leds, 0);
        repeat (3) press(1'b0, 1'b1);
        check("browse_idx3", row_idx, 3);
        check("browse_leds3", row_leds, 16'hA5A5);

        // Button held across reset release counts as one edge
        rst_n = 1'b0;
        BtnD  = 1'b1;
        tick();
        tick();
        check("rst_idx_again", row_idx, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("edge_after_reset", row_idx, 1);
        BtnD = 1'b0;
        tick();
        press(1'b1, 1'b0);
        check("up_to_0", row_idx, 0);
        press(1'b1, 1'b0);
        check("sat_low", row_idx, 0);
        repeat (20) press(1'b0, 1'b1);
        check("sat_high", row_idx, 15);
        BtnU = 1'b1;
        repeat (6) tick();
        BtnU = 1'b0;
        tick();
        check("hold_one_step", row_idx, 14);
        press(1'b1, 1'b1);
        check("both_no_change", row_idx, 14);

        // Full stream, sink always ready
        for (int r = 0; r < ROWS; r++) b[r*COLS +: COLS] = 16'h0100 + 16'(r);
        start_stream(b, 1'b0);
        run_stream(1'b0, 1'b0, ROWS);
        check("end1_valid", stream_valid, 0);
        check("end1_busy", busy, 0);

        // Random back-pressure with mid-stream disturbances and enable dropped
        for (int r = 0; r < ROWS; r++) b[r*COLS +: COLS] = {4'hC, 4'(r), ~4'(r), 4'(r)};
        start_stream(b, 1'b0);
        run_stream(1'b1, 1'b1, ROWS);
        check("end2_valid", stream_valid, 0);
        check("end2_busy", busy, 0);
        check("browse_frozen", row_leds, exp_board[14*COLS +: COLS]);

        // Back-to-back stream with snapshot asserted alongside the start
        for (int r = 0; r < ROWS; r++) b[r*COLS +: COLS] = 16'h3000 + 16'(r) * 16'h0101;
        start_stream(b, 1'b1);
        run_stream(1'b1, 1'b0, ROWS);
        check("end3_valid", stream_valid, 0);
        check("end3_busy", busy, 0);
        repeat (2) tick();
        check("snap_with_start", row_leds, b[14*COLS +: COLS]);

        // Reset during a stream after 7 beats
        for (int r = 0; r < ROWS; r++) b[r*COLS +: COLS] = 16'h5A00 + 16'(r);
        start_stream(b, 1'b0);
        run_stream(1'b0, 1'b0, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", stream_valid, 0);
        check("midrst_data", stream_data, 0);
        check("midrst_last", stream_last, 0);
        check("midrst_busy", busy, 0);
        check("midrst_idx", row_idx, 0);
        check("midrst_leds", row_leds, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_valid", stream_valid, 0);
        check("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/board_reader.md
BOARD_READER -- requirements
Module: board_reader

Interface
REQ-001 The parameter list SHALL be: ROWS, 16, number of board rows; COLS, 16, cells per row (board width ROWS*COLS).
REQ-002 The port clk SHALL be input, width 1, the single clock; every register in the block is clocked on its rising edge.
REQ-003 The port rst_n SHALL be input, width 1, the asynchronous active-low reset.
REQ-004 The port enable SHALL be input, width 1, and gates snapshot, browsing and stream start.
REQ-005 The ports BtnU and BtnD SHALL be inputs, width 1 each, synchronous level buttons that move the browse row up and down.
REQ-006 The port snapshot SHALL be input, width 1, and captures board_in into the shadow board.
REQ-007 The port board_in SHALL be input, width ROWS*COLS, the live board; row r occupies bits [r*COLS +: COLS].
REQ-008 The port stream_start SHALL be input, width 1, and requests a full-board row stream.
REQ-009 The port stream_ready SHALL be input, width 1, the sink-ready signal.
REQ-010 The port row_leds SHALL be output, width COLS, the shadow row at the current browse index.
REQ-011 The port row_idx SHALL be output, width 4, the current browse index.
REQ-012 The port stream_data SHALL be output, width COLS, the row currently offered to the sink.
REQ-013 The port stream_valid SHALL be output, width 1, and qualifies stream_data.
REQ-014 The port stream_last SHALL be output, width 1, and marks the final row (ROWS-1) of a stream.
REQ-015 The port busy SHALL be output, width 1, and is high while the stream is not idle.

Function
REQ-016 The shadow board SHALL load board_in in the cycle after snapshot=1 and enable=1 are sampled with the FSM in IDLE.
REQ-017 Browsing SHALL act only on the rising edge of BtnU or BtnD, meaning a 0->1 change between consecutive samples, with enable=1.
REQ-018 A BtnU edge SHALL decrement row_idx, saturating at 0.
REQ-019 A BtnD edge SHALL increment row_idx, saturating at ROWS-1.
REQ-020 BtnU and BtnD edges in the same cycle SHALL leave row_idx unchanged.
REQ-021 Holding a button high SHALL move row_idx by exactly one row.
REQ-022 row_leds SHALL be registered and SHALL equal shadow[row_idx*COLS +: COLS] with 1-cycle latency after either row_idx or the shadow board changes.
REQ-023 The stream FSM SHALL have the states IDLE and SEND.
REQ-024 IDLE -> SEND SHALL occur on stream_start=1 with enable=1; in the same edge the shadow board loads board_in and the stream pointer is set to 0.
REQ-025 In SEND, stream_valid SHALL be 1 and stream_data SHALL equal shadow row[ptr].
REQ-026 stream_last SHALL be 1 exactly when ptr equals ROWS-1.
REQ-027 A beat SHALL complete on stream_valid=1 and stream_ready=1; ptr increments, or, if ptr is ROWS-1, the FSM returns to IDLE and stream_valid drops in the next cycle.
REQ-028 While stream_valid=1 and stream_ready=0, stream_data, stream_last and ptr SHALL hold stable.
REQ-029 stream_start and snapshot SHALL be ignored while busy=1.
REQ-030 Browsing SHALL remain active during SEND and SHALL read the frozen shadow board.
REQ-031 Deasserting enable during SEND SHALL NOT abort the stream, which completes all ROWS beats.
REQ-032 snapshot and stream_start asserted together in IDLE SHALL both load the same board_in and start the stream.
REQ-033 Back-to-back streams SHALL be possible: stream_start sampled in the first IDLE cycle after the last beat starts a new stream.

Reset
REQ-034 rst_n=0 SHALL immediately force: FSM=IDLE, ptr=0, row_idx=0, shadow board=0, row_leds=0, stream_data=0, stream_valid=0, stream_last=0, busy=0, edge-detect history=0.
REQ-035 A reset asserted mid-stream SHALL abandon the stream with no further valid beats.
REQ-036 After reset release, the first button edge SHALL be detected relative to the reset history value of 0.

Structure
REQ-037 A shared package SHALL hold ROWS, COLS, ROW_IDX_W (4) and the FSM state encoding, shared with the board writer and the update engine.
REQ-038 One sub-module, btn_edge (2-flop history, 1-cycle rising-edge pulse), SHALL be instantiated once per button.
REQ-039 A competent implementation SHALL fall within 120-400 lines of RTL.

Verification
REQ-040 Reset, then board_in row 3 = 16'hA5A5, snapshot pulse, 3 BtnD edges -> row_idx=3, row_leds=16'hA5A5 one cycle later.
REQ-041 Reset, BtnU edge at row 0, then 20 BtnD edges -> row_idx stays 0, then saturates at 15; BtnU and BtnD edges together -> no change.
REQ-042 board_in row r = 16'h0100+r, stream_start, stream_ready=1 -> 16 consecutive beats with data 0x0100..0x010F, stream_last only on 0x010F, busy falls after the 16th beat.
REQ-043 stream_ready toggled randomly -> each row is delivered exactly once in order, and data is stable while stalled.
REQ-044 board_in changes and snapshot/stream_start pulse mid-stream -> streamed data is unchanged and the extra requests are ignored.
REQ-045 rst_n pulsed low at beat 7 -> stream_valid=0 immediately and all outputs take their reset values.
